lcd_bus_monitor: RTL and testbench

Passive receiver for the HD44780-style 4-bit LCD bus driven by `LCD_module`. It samples `LCD_E/RS/RW/D` on the system clock, tracks the 8-bit to 4-bit init handshake, and reassembles nibble pairs into commands and characters. It keeps a shadow copy of the two visible 16-character rows, so on-chip logic and the bench can read back exactly what the panel shows.

---
 rtl/lcd_bus_monitor_pkg.sv | 45 ++++
 rtl/lcd_bus_monitor_if.sv | 16 +
 rtl/lcd_bus_monitor_nibble_rx.sv | 94 +++++++++
 rtl/lcd_bus_monitor.sv | 92 +++++++++
 tb/tb_lcd_bus_monitor.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_bus_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared opcodes, DDRAM map constants, FSM states and address step.
// Revision : 1.0
// ============================================================================
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR       = 8'h01;
  localparam logic [7:0] CMD_HOME        = 8'h02;
  localparam logic [7:0] CMD_ENTRY       = 8'h04;
  localparam logic [7:0] CMD_IGNORE_MASK = 8'h38;
  localparam logic [7:0] CMD_SET_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_SET_DDRAM   = 8'h80;

  localparam logic [6:0] ROW_A_BASE = 7'h00;
  localparam logic [6:0] ROW_B_BASE = 7'h40;
  localparam logic [6:0] LINE_END   = 7'h27;
  localparam logic [6:0] LINE2_END  = 7'h67;

  localparam logic [7:0]   CHAR_SPACE = 8'h20;
  localparam logic [127:0] ROW_BLANK  = {16{CHAR_SPACE}};

  typedef logic [1:0] state_t;
  localparam state_t INIT8 = 2'd0;
  localparam state_t HI    = 2'd1;
  localparam state_t LO    = 2'd2;

  // Two-line DDRAM map: each line ends at base+0x27 and wraps into the other.
  function automatic logic [6:0] addr_step(input logic [6:0] addr, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (addr == LINE_END)        nxt = ROW_B_BASE;
      else if (addr == LINE2_END)  nxt = ROW_A_BASE;
      else                         nxt = addr + 7'd1;
    end else begin
      if (addr == ROW_A_BASE)      nxt = LINE2_END;
      else if (addr == ROW_B_BASE) nxt = LINE_END;
      else                         nxt = addr - 7'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_if
// Purpose  : HD44780 4-bit bus signals; master drives, slave observes.
// Revision : 1.0
// ============================================================================
interface lcd_bus_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] LCD_D;

  modport master (output LCD_E, output LCD_RS, output LCD_RW, output LCD_D);
  modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW, input  LCD_D);
endinterface
`default_nettype wire

// File: rtl/lcd_bus_monitor_nibble_rx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_nibble_rx
// Purpose  : E falling-edge detect, 8-bit init tracking and nibble pairing.
// Revision : 1.0
// ============================================================================
module lcd_nibble_rx
  import lcd_pkg::*;
#(
  parameter int NIBBLE_TIMEOUT = 2_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  lcd_bus_if.slave   bus,
  output logic       mode_4bit,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       rs,
  output logic       rw
);

  localparam int CW = $clog2(NIBBLE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLE_TIMEOUT - 1);

  logic          e_q;
  logic          fall;
  state_t        state;
  logic [3:0]    hi_nib;
  logic          hi_rs;
  logic          hi_rw;
  logic [CW-1:0] cnt;

  assign fall = e_q & ~bus.LCD_E;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_q        <= 1'b0;
      state      <= INIT8;
      mode_4bit  <= 1'b0;
      hi_nib     <= 4'h0;
      hi_rs      <= 1'b0;
      hi_rw      <= 1'b0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'h00;
      rs         <= 1'b0;
      rw         <= 1'b0;
    end else begin
      e_q        <= bus.LCD_E;
      byte_valid <= 1'b0;
      if (fall) cnt <= '0;
      case (state)
        INIT8: begin
          if (fall && bus.LCD_D == 4'h2 && !bus.LCD_RS) begin
            state     <= HI;
            mode_4bit <= 1'b1;
          end
        end
        HI: begin
          if (fall) begin
            hi_nib <= bus.LCD_D;
            hi_rs  <= bus.LCD_RS;
            hi_rw  <= bus.LCD_RW;
            state  <= LO;
          end
        end
        LO: begin
          if (fall) begin
            // A control-line change means the pair is broken; restart on this nibble.
            if (bus.LCD_RS != hi_rs || bus.LCD_RW != hi_rw) begin
              hi_nib <= bus.LCD_D;
              hi_rs  <= bus.LCD_RS;
              hi_rw  <= bus.LCD_RW;
            end else begin
              byte_valid <= 1'b1;
              rx_byte    <= {hi_nib, bus.LCD_D};
              rs         <= hi_rs;
              rw         <= hi_rw;
              state      <= HI;
            end
          end else if (cnt == CNT_LAST) begin
            state <= HI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= INIT8;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_monitor
// Purpose  : Passive HD44780 bus receiver keeping a shadow of both visible rows.
// Revision : 1.0
// ============================================================================
module lcd_bus_monitor
  import lcd_pkg::*;
#(
  parameter int NIBBLE_TIMEOUT = 2_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  lcd_bus_if.slave     bus,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         char_wr,
  output logic [6:0]   ddram_addr,
  output logic         mode_4bit
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rs;
  logic       rw;
  logic       inc;
  logic       cg_sel;
  logic       is_cmd;
  logic       is_data;
  logic       wr_a;
  logic       wr_b;
  logic [3:0] col;

  lcd_nibble_rx #(.NIBBLE_TIMEOUT(NIBBLE_TIMEOUT)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .mode_4bit  (mode_4bit),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .rs         (rs),
    .rw         (rw)
  );

  assign is_cmd  = byte_valid & ~rw & ~rs;
  assign is_data = byte_valid & ~rw & rs;
  assign col     = ddram_addr[3:0];
  assign wr_a    = is_data & ~cg_sel & (ddram_addr[6:4] == ROW_A_BASE[6:4]);
  assign wr_b    = is_data & ~cg_sel & (ddram_addr[6:4] == ROW_B_BASE[6:4]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_A      <= ROW_BLANK;
      row_B      <= ROW_BLANK;
      ddram_addr <= 7'h00;
      inc        <= 1'b1;
      cg_sel     <= 1'b0;
      char_wr    <= 1'b0;
    end else begin
      char_wr <= 1'b0;
      if (is_cmd) begin
        if (|(rx_byte & CMD_SET_DDRAM)) begin
          ddram_addr <= rx_byte[6:0];
          cg_sel     <= 1'b0;
        end else if (|(rx_byte & CMD_SET_CGRAM)) begin
          cg_sel <= 1'b1;
        end else if (|(rx_byte & CMD_IGNORE_MASK)) begin
          // function set / display control / cursor shift: nothing to shadow
        end else if (|(rx_byte & CMD_ENTRY)) begin
          inc <= rx_byte[1];
        end else if (|(rx_byte & CMD_HOME)) begin
          ddram_addr <= 7'h00;
        end else if (|(rx_byte & CMD_CLEAR)) begin
          row_A      <= ROW_BLANK;
          row_B      <= ROW_BLANK;
          ddram_addr <= 7'h00;
          inc        <= 1'b1;
        end
      end
      if (is_data) begin
        char_wr    <= 1'b1;
        ddram_addr <= addr_step(ddram_addr, inc);
      end
      for (int i = 0; i < 16; i++) begin
        if (wr_a && col == 4'(i)) row_A[127-8*i -: 8] <= rx_byte;
        if (wr_b && col == 4'(i)) row_B[127-8*i -: 8] <= rx_byte;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_monitor
// Purpose  : Self-checking bench: vector table, char_wr scoreboard, corner cases.
// Revision : 1.0
// ============================================================================
module tb_lcd_bus_monitor;

  localparam int TO = 40;
  localparam logic [127:0] BLANK = {16{8'h20}};

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic [6:0] exp_addr;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] row_A;
  logic [127:0] row_B;
  logic         char_wr;
  logic [6:0]   ddram_addr;
  logic         mode_4bit;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_q[$];
  vec_t       vecs[13];

  lcd_bus_if bus ();

  lcd_bus_monitor #(.NIBBLE_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .row_A      (row_A),
    .row_B      (row_B),
    .char_wr    (char_wr),
    .ddram_addr (ddram_addr),
    .mode_4bit  (mode_4bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every char_wr pulse must match a queued data write and its post-step address.
  always @(negedge clk) begin
    logic [6:0] e;
    if (char_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL char_wr: unexpected pulse, addr=%h", ddram_addr);
      end else begin
        e = exp_q.pop_front();
        if (ddram_addr !== e) begin
          errors++;
          $display("FAIL char_wr_addr: got %h want %h", ddram_addr, e);
        end
      end
    end
  end

  task automatic send_nibble(input logic rs, input logic rw, input logic [3:0] d);
    @(negedge clk);
    bus.LCD_RS = rs;
    bus.LCD_RW = rw;
    bus.LCD_D  = d;
    bus.LCD_E  = 1'b1;
    @(negedge clk);
    bus.LCD_E  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_nibble(1'b0, 1'b0, b[7:4]);
    send_nibble(1'b0, 1'b0, b[3:0]);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] b, input logic [6:0] exp_addr);
    exp_q.push_back(exp_addr);
    send_nibble(1'b1, 1'b0, b[7:4]);
    send_nibble(1'b1, 1'b0, b[3:0]);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [127:0] exp_a;
    logic [127:0] exp_b;
    logic [127:0] msg;
    logic [31:0]  s_fibo;

    msg    = "show a message..";
    s_fibo = "Fibo";
    vecs[0]  = '{1'b0, 8'h80, 7'h00};
    vecs[1]  = '{1'b1, "F",   7'h01};
    vecs[2]  = '{1'b1, "i",   7'h02};
    vecs[3]  = '{1'b1, "b",   7'h03};
    vecs[4]  = '{1'b1, "o",   7'h04};
    vecs[5]  = '{1'b0, 8'hE7, 7'h67};
    vecs[6]  = '{1'b1, "Z",   7'h00};
    vecs[7]  = '{1'b0, 8'h84, 7'h04};
    vecs[8]  = '{1'b0, 8'h03, 7'h00};
    vecs[9]  = '{1'b0, 8'h40, 7'h00};
    vecs[10] = '{1'b1, "W",   7'h01};
    vecs[11] = '{1'b0, 8'h0F, 7'h01};
    vecs[12] = '{1'b0, 8'h80, 7'h00};

    bus.LCD_E = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_D = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_mode", 128'(mode_4bit), 128'(1'b0));
    check("rst_row_A", row_A, BLANK);
    check("rst_row_B", row_B, BLANK);
    check("rst_addr", 128'(ddram_addr), 128'(7'h00));
    check("rst_char_wr", 128'(char_wr), 128'(1'b0));
    reset_n = 1'b1;

    repeat (3) send_nibble(1'b0, 1'b0, 4'h3);
    repeat (2) @(negedge clk);
    check("init_after_3s", 128'(mode_4bit), 128'(1'b0));
    send_nibble(1'b0, 1'b0, 4'h2);
    repeat (2) @(negedge clk);
    check("init_mode4", 128'(mode_4bit), 128'(1'b1));
    send_cmd(8'h28);
    check("init_rows", row_A | row_B, BLANK);
    check("init_addr", 128'(ddram_addr), 128'(7'h00));

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rs) send_data(vecs[i].b, vecs[i].exp_addr);
      else            send_cmd(vecs[i].b);
      check($sformatf("vec%0d_addr", i), 128'(ddram_addr), 128'(vecs[i].exp_addr));
    end
    exp_a = BLANK;
    exp_a[127:96] = s_fibo;
    check("fibo_row_A", row_A, exp_a);
    check("fibo_row_B", row_B, BLANK);

    send_cmd(8'hC0);
    for (int i = 0; i < 16; i++) send_data(msg[127-8*i -: 8], 7'(7'h41 + i));
    check("msg_row_B", row_B, msg);
    check("msg_addr", 128'(ddram_addr), 128'(7'h50));

    send_cmd(8'hA7);
    send_data("X", 7'h40);
    check("x_addr", 128'(ddram_addr), 128'(7'h40));
    check("x_row_A", row_A, exp_a);
    check("x_row_B", row_B, msg);
    send_cmd(8'h04);
    send_data("Y", 7'h27);
    exp_b = msg;
    exp_b[127:120] = "Y";
    check("y_row_B", row_B, exp_b);
    check("y_addr", 128'(ddram_addr), 128'(7'h27));

    send_cmd(8'h80);
    send_data("q", 7'h67);
    exp_a[127:120] = "q";
    check("dec_wrap_row_A", row_A, exp_a);
    check("dec_wrap_addr", 128'(ddram_addr), 128'(7'h67));

    // Broken pair: RS flips after the high nibble, so 0x80 must still decode cleanly.
    send_nibble(1'b1, 1'b0, 4'h4);
    send_cmd(8'h80);
    check("mismatch_addr", 128'(ddram_addr), 128'(7'h00));
    check("mismatch_row_A", row_A, exp_a);

    send_nibble(1'b0, 1'b0, 4'h4);
    repeat (TO + 2) @(negedge clk);
    send_cmd(8'h01);
    check("timeout_row_A", row_A, BLANK);
    check("timeout_row_B", row_B, BLANK);
    check("timeout_addr", 128'(ddram_addr), 128'(7'h00));
    send_data("a", 7'h01);
    exp_a = BLANK;
    exp_a[127:120] = "a";
    check("clear_id_row_A", row_A, exp_a);

    send_nibble(1'b1, 1'b0, 4'h4);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_nibble(1'b1, 1'b0, 4'h1);
    repeat (4) @(negedge clk);
    check("midrst_mode", 128'(mode_4bit), 128'(1'b0));
    check("midrst_row_A", row_A, BLANK);
    check("midrst_addr", 128'(ddram_addr), 128'(7'h00));

    check("pending_writes", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
